// File: rtl/responder.sv
// NoC register-read responder: queues addressed requests in a small FIFO and
// answers each with the contents of a 16 x 6-bit local register file.
module responder #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       id,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             writeIn,
  output logic             fullIn,
  output logic             almost_fullIn,
  input  logic             full,
  input  logic             almost_full,
  output logic [WIDTH-1:0] dataOut,
  output logic             write,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [5:0]       wr_data,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  // Only the fields needed to build the response are queued.
  typedef struct packed {
    logic [3:0] reg_idx;
    logic [1:0] src;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [5:0]       r_regfile [16];
  logic             r_write;
  logic             r_drop;
  logic [WIDTH-1:0] r_data_out;

  logic             w_accept;
  logic             w_issue;
  entry_t           w_head;
  logic [WIDTH-1:0] w_resp;
  logic             w_unused;

  assign w_unused = ^{dataIn[WIDTH-1:11], dataIn[10:9]};

  assign w_accept = writeIn & dataIn[0] & (dataIn[2:1] == id) & (r_count != CNT_FULL);
  // Backpressure is judged against what we sent last cycle: a write in flight
  // already consumes the egress slot that almost_full reports as the last one.
  assign w_issue  = (r_count != '0) & ~((r_write & almost_full) | (~r_write & full));
  assign w_head   = r_mem[r_rd_ptr];

  assign fullIn        = (r_count == CNT_FULL);
  assign almost_fullIn = (r_count >= CNT_FULL - 1'b1);

  // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_resp       = '0;
    w_resp[11]   = 1'b1;
    w_resp[10:5] = r_regfile[w_head.reg_idx];
    w_resp[4:3]  = id;
    w_resp[2:1]  = w_head.src;
    w_resp[0]    = 1'b1;
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= '{reg_idx: dataIn[8:5], src: dataIn[4:3]};
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_write    <= 1'b0;
      r_drop     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_drop  <= writeIn & ~w_accept;
      r_write <= w_issue;
      if (w_issue) begin
        r_data_out <= w_resp;
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      case ({w_accept, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Register file contents are architecturally defined in reset (16*id + index),
  // so unlike the FIFO it is reset entry by entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) r_regfile[i] <= {id, 4'(i)};
    end else if (wr_en) begin
      r_regfile[wr_addr] <= wr_data;
    end
  end

  assign dataOut = r_data_out;
  assign write   = r_write;
  assign drop    = r_drop;

endmodule

// File: tb/tb_responder.sv
// Randomized scoreboard bench for responder: a queue-based reference model
// predicts responses, drops and FIFO flags; a monitor checks them every cycle.
module tb_responder;
  localparam int WIDTH = 12;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       id;
  logic [WIDTH-1:0] dataIn;
  logic             writeIn;
  logic             fullIn;
  logic             almost_fullIn;
  logic             full;
  logic             almost_full;
  logic [WIDTH-1:0] dataOut;
  logic             write;
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [5:0]       wr_data;
  logic             drop;

  responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .id(id), .dataIn(dataIn), .writeIn(writeIn),
    .fullIn(fullIn), .almost_fullIn(almost_fullIn), .full(full),
    .almost_full(almost_full), .dataOut(dataOut), .write(write),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int src;
  } req_t;

  // Reference model state: pending requests, register file, expected responses.
  req_t             mq[$];
  int               m_rf[16];
  logic [WIDTH-1:0] exp_q[$];
  bit               m_write;
  bit               exp_drop;
  logic [WIDTH-1:0] m_last;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mon_en  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] pkt(input int src, input int dst, input int rid, input bit v);
    logic [5:0] r = rid[5:0];
    logic [1:0] s = src[1:0];
    logic [1:0] d = dst[1:0];
    return {1'b0, r, s, d, v};
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_write  = 0;
    exp_drop = 0;
    m_last   = '0;
    for (int i = 0; i < 16; i++) m_rf[i] = (16 * int'(id) + i) % 64;
  endtask

  // Apply one cycle of inputs (called at a negedge) and advance the model to
  // the state the DUT should reach on the following rising edge.
  task automatic step(input bit wi, input logic [WIDTH-1:0] d, input bit f, input bit af,
                      input bit we, input logic [3:0] wa, input logic [5:0] wd);
    bit issue, accept;
    writeIn = wi; dataIn = d; full = f; almost_full = af;
    wr_en = we; wr_addr = wa; wr_data = wd;
    issue  = (mq.size() > 0) && !(m_write ? af : f);
    accept = wi && d[0] && (d[2:1] == id) && (mq.size() < DEPTH);
    if (issue) begin
      req_t h = mq.pop_front();
      m_last = WIDTH'(2048 + m_rf[h.idx] * 32 + int'(id) * 8 + h.src * 2 + 1);
      exp_q.push_back(m_last);
    end
    if (accept) mq.push_back('{idx: int'(d[8:5]), src: int'(d[4:3])});
    if (we) m_rf[wa] = int'(wd);
    exp_drop = wi && !accept;
    m_write  = issue;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit f = 0, input bit af = 0);
    for (int i = 0; i < n; i++) step(0, '0, f, af, 0, 4'd0, 6'd0);
  endtask

  task automatic apply_reset(input logic [1:0] new_id);
    reset = 1'b0;
    writeIn = 0; dataIn = '0; wr_en = 0; full = 0; almost_full = 0;
    #1;
    check("rst_write", write, 0);
    check("rst_dataOut", dataOut, 0);
    check("rst_drop", drop, 0);
    check("rst_fullIn", fullIn, 0);
    check("rst_almost_fullIn", almost_fullIn, 0);
    id = new_id;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      check("write", write, m_write);
      check("drop", drop, exp_drop);
      check("fullIn", fullIn, mq.size() == DEPTH);
      check("almost_fullIn", almost_fullIn, mq.size() >= DEPTH - 1);
      if (write) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL resp_unexpected: got %0h, expected no response (t=%0t)", dataOut, $time);
        end else begin
          check("resp_data", dataOut, exp_q.pop_front());
        end
      end else begin
        check("dataOut_hold", dataOut, m_last);
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] d;
    reset = 1'b0; id = 2'd2;
    writeIn = 0; dataIn = '0; full = 0; almost_full = 0;
    wr_en = 0; wr_addr = '0; wr_data = '0;
    model_reset();
    @(negedge clk);
    apply_reset(2'd2);
    mon_en = 1;

    // Basic request: reg 37, source 1, destination id.
    step(1, pkt(1, 2, 37, 1), 0, 0, 0, 4'd0, 6'd0);
    idle(1);
    check("basic_latency_write", write, 1);
    check("basic_resp", dataOut, 12'hCB3);
    idle(2);

    // Wrong destination and invalid packet are both dropped.
    step(1, pkt(0, 3, 4, 1), 0, 0, 0, 4'd0, 6'd0);
    step(1, pkt(0, 2, 4, 0), 0, 0, 0, 4'd0, 6'd0);
    idle(2);

    // Egress full: five back-to-back requests, the fifth overflows.
    for (int i = 0; i < 5; i++) step(1, pkt(i % 4, 2, i + 1, 1), 1, 0, 0, 4'd0, 6'd0);
    check("ovf_fullIn", fullIn, 1);
    check("ovf_drop", drop, 1);
    idle(7);

    // almost_full while a write is in flight stalls the next response.
    for (int i = 0; i < 3; i++) step(1, pkt(3, 2, 8 + i, 1), 1, 0, 0, 4'd0, 6'd0);
    idle(1);
    idle(2, 0, 1);
    idle(4);

    // Same-edge register write and issue: old value goes out, new value next.
    step(1, pkt(0, 2, 5, 1), 0, 0, 0, 4'd0, 6'd0);
    step(0, '0, 0, 0, 1, 4'd5, 6'h3F);
    check("rf_old_value", dataOut[10:5], 6'd37);
    step(1, pkt(0, 2, 5, 1), 0, 0, 0, 4'd0, 6'd0);
    idle(1);
    check("rf_new_value", dataOut[10:5], 6'h3F);
    idle(2);

    // Reset with three entries queued: nothing emerges afterwards.
    for (int i = 0; i < 3; i++) step(1, pkt(1, 2, 20 + i, 1), 1, 0, 0, 4'd0, 6'd0);
    apply_reset(2'd1);
    idle(6);

    // Randomized traffic, with one mid-run reset to a different node id.
    for (int n = 0; n < 3000; n++) begin
      int dst;
      if (n == 1500) apply_reset(2'd3);
      dst = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'(id);
      d = pkt($urandom_range(0, 3), dst, $urandom_range(0, 63), $urandom_range(0, 9) != 0);
      step($urandom_range(0, 9) < 7, d, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) < 3, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)));
    end

    idle(10);
    check("drain_empty", exp_q.size(), 0);
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/responder.md
RESPONDER -- requirements
Module: responder

Interface
REQ-001 SHALL have parameter WIDTH, default 12, giving the packet width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, giving the ingress FIFO entries; it SHALL be a power of 2 and at least 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; asserted when 0.
REQ-005 id  input  2  node number of this responder; static during operation.
REQ-006 dataIn  input  WIDTH  request packet from the NoC.
REQ-007 writeIn  input  1  dataIn is valid this cycle.
REQ-008 fullIn  output  1  ingress FIFO holds DEPTH entries.
REQ-009 almost_fullIn  output  1  ingress FIFO holds at least DEPTH-1 entries.
REQ-010 full  input  1  NoC egress is full.
REQ-011 almost_full  input  1  NoC egress has one slot left.
REQ-012 dataOut  output  WIDTH  registered response packet to the NoC.
REQ-013 write  output  1  registered; dataOut is valid this cycle.
REQ-014 wr_en  input  1  local register-file write strobe.
REQ-015 wr_addr  input  4  local register index.
REQ-016 wr_data  input  6  local register write value.
REQ-017 drop  output  1  registered one-cycle pulse when an incoming packet is discarded.

Function
REQ-018 Request packet format: bit 11 is 0 (ignored on input); bits [10:5] are the register id; [4:3] are the source; [2:1] are the destination; [0] is valid.
REQ-019 A request SHALL be accepted when writeIn=1, dataIn[0]=1, dataIn[2:1]==id, and the FIFO count < DEPTH; the entry is pushed on that edge.
REQ-020 A request SHALL be discarded, with drop=1 on the next cycle, when writeIn=1 and any of these hold: dataIn[0]=0, the destination does not match id, or count==DEPTH.
REQ-021 count==DEPTH SHALL reject a push even if a pop occurs on the same edge; a simultaneous push and pop below full SHALL leave count unchanged.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; count SHALL range from 0 to DEPTH.
REQ-023 The register file SHALL have 16 entries of 6 bits; the index is register id [3:0].
REQ-024 When wr_en=1, regfile[wr_addr] SHALL be updated at the edge.
REQ-025 Issue condition: FIFO non-empty and not ((write & almost_full) | (~write & full)).
REQ-026 On issue, the FIFO head SHALL be popped and the response registered into dataOut with write=1 on the same edge.
REQ-027 When the issue condition is false, write SHALL be 0 next cycle and dataOut SHALL hold its value.
REQ-028 Response format: bit 11 = 1 (response flag); [10:5] = regfile[head reg id[3:0]]; [4:3] = id; [2:1] = head source; [0] = 1.
REQ-029 Minimum latency: a request accepted at edge N into an empty FIFO SHALL appear with write=1 after edge N+1.
REQ-030 Sustained throughput SHALL be one response per cycle while full=0 and almost_full=0.
REQ-031 On a same-edge wr_en and issue to the same index, the response SHALL carry the old value.
REQ-032 fullIn and almost_fullIn SHALL be decoded combinationally from the registered count.

Reset
REQ-033 While reset=0: write=0, dataOut=0, drop=0, count=0, and both pointers=0.
REQ-034 While reset=0: regfile[i]=16*id+i, truncated to 6 bits.
REQ-035 Reset asserted mid-operation SHALL discard all queued requests immediately; no partial packet SHALL be emitted after reset releases.
REQ-036 The first accepted request SHALL be the first edge after reset=1 with writeIn=1.

Verification
REQ-037 id=2, after reset, inject dataIn={0,6'd37,2'd1,2'd2,1'b1} -> two edges later write=1, dataOut={1,6'd37,2'd2,2'd1,1}.
REQ-038 id=2, dest=3 packet and a valid=0 packet -> drop pulses once each, no write, count stays 0.
REQ-039 full=1, inject 5 valid requests back-to-back -> 4 accepted, fullIn=1, fifth produces drop=1; release full -> 4 responses in order, one per cycle.
REQ-040 write=1 with almost_full=1 -> write=0 next cycle, head retained, sent after almost_full=0.
REQ-041 wr_en to index 5 with value 6'h3F on the same edge as a reg-5 response issues -> response carries 16*id+5; the next reg-5 request returns 6'h3F.
REQ-042 Assert reset with 3 entries queued -> write=0 at once, count=0, no responses after release.
